// File: rtl/student_cpu_pkg.sv
// ============================================================================
// Module      : student_cpu_pkg
// Description : Shared types and constants for the student CPU fetch/exec
//               controller: controller state encoding, instruction-word bit
//               positions and the default fetch timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package student_cpu_pkg;

  // Controller states, explicitly 3 bits wide.
  typedef enum logic [2:0] {
    ST_RST_PC = 3'd0,
    ST_IDLE   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Instruction word layout.
  localparam int unsigned IR_W         = 16;
  localparam int unsigned OPCODE_BIT   = 15;  // 1 = C-instruction, 0 = A-instruction
  localparam int unsigned JMP_NEG_BIT  = 2;   // jump if result < 0
  localparam int unsigned JMP_ZERO_BIT = 1;   // jump if result == 0
  localparam int unsigned JMP_POS_BIT  = 0;   // jump if result > 0

  // Fetch timeout: cycles in FETCH without rom_ack before FAULT.
  localparam int unsigned MAX_WAIT_DEFAULT = 15;
  localparam int unsigned WAIT_W           = 8;  // holds up to 255

  // Retired-instruction counter width.
  localparam int unsigned RET_W = 16;

endpackage

`default_nettype wire

// File: rtl/student_jump_unit.sv
// ============================================================================
// Module      : student_jump_unit
// Description : Combinational jump decode. A C-instruction jumps when any of
//               its selected conditions (neg / zero / pos) matches the ALU
//               flags; an A-instruction never jumps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module student_jump_unit
  import student_cpu_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  input  logic            zr,
  input  logic            ng,
  output logic            jump
);

  // Positive means neither zero nor negative.
  assign jump = ir[OPCODE_BIT] &
                ((ir[JMP_NEG_BIT]  & ng) |
                 (ir[JMP_ZERO_BIT] & zr) |
                 (ir[JMP_POS_BIT]  & ~zr & ~ng));

endmodule

`default_nettype wire

// File: rtl/student_fetch_ctrl.sv
// ============================================================================
// Module      : student_fetch_ctrl
// Description : Fetch/execute sequencer for the student CPU. Requests an
//               instruction from ROM, latches it, commits it in a single EXEC
//               cycle with PC load/increment, and supports halt, single-step
//               and a sticky fetch-timeout fault.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module student_fetch_ctrl
  import student_cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             step,
  input  logic [IR_W-1:0]  instr,
  input  logic             rom_ack,
  input  logic             zr,
  input  logic             ng,
  output logic             rom_req,
  output logic [IR_W-1:0]  ir,
  output logic             exec_en,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             pc_reset,
  output logic             halted,
  output logic             fault,
  output logic [RET_W-1:0] retired
);

  // Wait-counter value on the last permitted ackless FETCH cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_e             state_q;
  logic [IR_W-1:0]    ir_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               step_mode_q;
  logic               halt_pend_q;   // halt_req seen while a fetch was in flight
  logic [RET_W-1:0]   retired_q;
  logic [RET_W-1:0]   retired_d;
  logic               w_exec;
  logic               w_jump;

  student_jump_unit u_jump (
    .ir   (ir_q),
    .zr   (zr),
    .ng   (ng),
    .jump (w_jump)
  );

  // Sequencer: state, latched instruction, fetch timeout, step and halt flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST_PC;
      ir_q        <= '0;
      wait_q      <= '0;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RST_PC: state_q <= ST_IDLE;

        ST_IDLE: begin
          if (run) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
          end
        end

        ST_FETCH: begin
          // A halt request never aborts a fetch; remember it for EXEC.
          if (halt_req) halt_pend_q <= 1'b1;
          if (rom_ack) begin
            ir_q    <= instr;
            state_q <= ST_EXEC;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= ST_FAULT;
          end else begin
            wait_q <= wait_q + WAIT_ONE;
          end
        end

        ST_EXEC: begin
          if (halt_req || halt_pend_q || step_mode_q) begin
            state_q     <= ST_HALT;
            halt_pend_q <= 1'b0;
          end else begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
          end
        end

        ST_HALT: begin
          // run has priority over step and leaves step mode.
          if (run) begin
            step_mode_q <= 1'b0;
            state_q     <= ST_FETCH;
            wait_q      <= '0;
          end else if (step) begin
            step_mode_q <= 1'b1;
            state_q     <= ST_FETCH;
            wait_q      <= '0;
          end
        end

        ST_FAULT: state_q <= ST_FAULT;

        default: state_q <= ST_FAULT;
      endcase
    end
  end

  // Retired count advances once per committed instruction, wrapping naturally.
  always_comb begin
    retired_d = retired_q;
    if (w_exec) retired_d = retired_q + RET_W'(1);
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  // Outputs decode straight from the state register so that reset takes
  // effect on them immediately, without waiting for a clock.
  assign w_exec   = (state_q == ST_EXEC);
  assign rom_req  = (state_q == ST_FETCH);
  assign exec_en  = w_exec;
  assign pc_load  = w_exec &  w_jump;
  assign pc_inc   = w_exec & ~w_jump;
  assign pc_reset = (state_q == ST_RST_PC);
  assign halted   = (state_q == ST_HALT);
  assign fault    = (state_q == ST_FAULT);
  assign ir       = ir_q;
  assign retired  = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_student_fetch_ctrl.sv
// ============================================================================
// Module      : tb_student_fetch_ctrl
// Description : Self-checking bench for student_fetch_ctrl: directed scenarios
//               followed by randomized stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_student_fetch_ctrl;

  localparam int MAXW = 3;

  logic        clk = 1'b0;
  logic        reset, run, halt_req, step, rom_ack, zr, ng;
  logic [15:0] instr;
  logic        rom_req, exec_en, pc_load, pc_inc, pc_reset, halted, fault;
  logic [15:0] ir, retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  student_fetch_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .halt_req (halt_req),
    .step     (step),
    .instr    (instr),
    .rom_ack  (rom_ack),
    .zr       (zr),
    .ng       (ng),
    .rom_req  (rom_req),
    .ir       (ir),
    .exec_en  (exec_en),
    .pc_load  (pc_load),
    .pc_inc   (pc_inc),
    .pc_reset (pc_reset),
    .halted   (halted),
    .fault    (fault),
    .retired  (retired)
  );

  // Behavioural reference model
  typedef enum {M_RST, M_IDLE, M_FETCH, M_EXEC, M_HALT, M_FAULT} mphase_t;
  mphase_t     m_ph;
  int          m_wait;
  int          m_cnt;
  logic [15:0] m_ir;
  bit          m_step;
  bit          m_halt_wanted;

  function automatic bit ref_jump(input logic [15:0] w, input logic z, input logic n);
    bit lt = (n == 1'b1);
    bit eq = (z == 1'b1);
    bit gt = (z == 1'b0) && (n == 1'b0);
    if (w < 16'h8000) return 1'b0;
    return (((w & 16'h0004) != 0) && lt) ||
           (((w & 16'h0002) != 0) && eq) ||
           (((w & 16'h0001) != 0) && gt);
  endfunction

  // {rom_req, exec_en, pc_load, pc_inc, pc_reset, halted, fault}
  function automatic logic [6:0] exp_ctrl();
    bit j  = ref_jump(m_ir, zr, ng);
    bit ex = (m_ph == M_EXEC);
    return {m_ph == M_FETCH, ex, ex && j, ex && !j, m_ph == M_RST,
            m_ph == M_HALT, m_ph == M_FAULT};
  endfunction

  task automatic model_reset();
    m_ph = M_RST; m_wait = 0; m_cnt = 0; m_ir = 16'h0000;
    m_step = 1'b0; m_halt_wanted = 1'b0;
  endtask

  task automatic model_clock();
    if (reset) begin
      model_reset();
      return;
    end
    case (m_ph)
      M_RST:  m_ph = M_IDLE;
      M_IDLE: if (run) begin m_ph = M_FETCH; m_wait = 0; end
      M_FETCH: begin
        if (halt_req) m_halt_wanted = 1'b1;
        if (rom_ack) begin
          m_ir = instr;
          m_ph = M_EXEC;
        end else begin
          m_wait++;
          if (m_wait >= MAXW) m_ph = M_FAULT;
        end
      end
      M_EXEC: begin
        m_cnt = (m_cnt + 1) % 65536;
        if (halt_req || m_halt_wanted || m_step) begin
          m_ph = M_HALT;
          m_halt_wanted = 1'b0;
        end else begin
          m_ph = M_FETCH;
          m_wait = 0;
        end
      end
      M_HALT: begin
        if (run)       begin m_step = 1'b0; m_ph = M_FETCH; m_wait = 0; end
        else if (step) begin m_step = 1'b1; m_ph = M_FETCH; m_wait = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then compare all outputs against the model.
  task automatic drive(input logic rs, input logic r, input logic h, input logic s,
                       input logic a, input logic [15:0] w, input logic z, input logic n);
    reset = rs; run = r; halt_req = h; step = s; rom_ack = a; instr = w; zr = z; ng = n;
    if (rs) model_reset();
    #2;
    check_val("ctrl", {rom_req, exec_en, pc_load, pc_inc, pc_reset, halted, fault}, exp_ctrl());
    check_val("ir", ir, m_ir);
    check_val("retired", retired, m_cnt[15:0]);
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  logic        rr, rh, rs, ra, rz, rn, rrst;
  logic [15:0] rw;
  logic [15:0] ret_before;

  initial begin
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; step = 1'b0;
    rom_ack = 1'b0; instr = 16'h0000; zr = 1'b0; ng = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    drive(1, 0, 0, 0, 0, 16'h0000, 0, 0);
    check_val("rst_ctrl", {rom_req, exec_en, pc_load, pc_inc, pc_reset, halted, fault}, 7'b0000100);
    check_val("rst_ir", ir, 16'h0000);
    check_val("rst_retired", retired, 16'h0000);
    advance();

    // First instruction after release
    drive(0, 1, 0, 0, 0, 16'h0000, 0, 0);
    check_val("pc_reset_cycle1", pc_reset, 1);
    advance();
    drive(0, 1, 0, 0, 0, 16'h0000, 0, 0);
    check_val("idle_no_req", rom_req, 0);
    advance();
    drive(0, 1, 0, 0, 1, 16'h0005, 0, 0);
    check_val("fetch_req", rom_req, 1);
    advance();
    drive(0, 1, 0, 0, 0, 16'h0000, 0, 0);
    check_val("first_exec_en", exec_en, 1);
    check_val("first_exec_inc", pc_inc, 1);
    check_val("first_exec_ir", ir, 16'h0005);
    advance();
    check_val("retired_one", retired, 16'h0001);

    // JEQ with zero / with negative
    drive(0, 1, 0, 0, 1, 16'hE302, 0, 0); advance();
    drive(0, 1, 0, 0, 0, 16'h0000, 1, 0);
    check_val("jeq_zr_load", pc_load, 1);
    check_val("jeq_zr_inc", pc_inc, 0);
    advance();
    drive(0, 1, 0, 0, 1, 16'hE302, 0, 0); advance();
    drive(0, 1, 0, 0, 0, 16'h0000, 0, 1);
    check_val("jeq_ng_inc", pc_inc, 1);
    check_val("jeq_ng_load", pc_load, 0);
    advance();

    // JMP with arbitrary flags, then an A-instruction
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 1, 16'hE307, 0, 0); advance();
      rz = ($urandom_range(0, 1) == 1); rn = ($urandom_range(0, 1) == 1);
      drive(0, 1, 0, 0, 0, 16'h0000, rz, rn);
      check_val("jmp_load", pc_load, 1);
      advance();
    end
    drive(0, 1, 0, 0, 1, 16'h7FFF, 0, 0); advance();
    rz = ($urandom_range(0, 1) == 1); rn = ($urandom_range(0, 1) == 1);
    drive(0, 1, 0, 0, 0, 16'h0000, rz, rn);
    check_val("ainstr_inc", pc_inc, 1);
    advance();

    // halt_req mid-fetch: the fetch completes, then HALT
    drive(0, 1, 1, 0, 0, 16'h0000, 0, 0); advance();
    drive(0, 1, 0, 0, 0, 16'h0000, 0, 0); advance();
    drive(0, 1, 0, 0, 1, 16'h0010, 0, 0);
    check_val("halt_fetch_kept", rom_req, 1);
    advance();
    drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    check_val("halt_exec_done", exec_en, 1);
    advance();
    drive(0, 0, 1, 0, 0, 16'h0000, 0, 0);
    check_val("halted_set", halted, 1);
    advance();
    drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    check_val("halt_req_ignored", halted, 1);
    ret_before = m_cnt[15:0];
    advance();

    // Single step: one instruction, back to HALT
    drive(0, 0, 0, 1, 0, 16'h0000, 0, 0); advance();
    drive(0, 0, 0, 0, 1, 16'h0123, 0, 0); advance();
    drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    check_val("step_exec", exec_en, 1);
    advance();
    drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    check_val("step_halted", halted, 1);
    check_val("step_retired", retired, ret_before + 16'd1);
    advance();

    // run and step together: run wins, continuous execution
    drive(0, 1, 0, 1, 0, 16'h0000, 0, 0); advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 1, 16'h0040 + 16'(i), 0, 0); advance();
      drive(0, 1, 0, 0, 0, 16'h0000, 0, 0); advance();
      drive(0, 1, 0, 0, 0, 16'h0000, 0, 0);
      check_val("run_continuous", rom_req, 1);
      if (i < 2) begin
        rom_ack = 1'b1; instr = 16'h0041; advance();
        drive(0, 1, 0, 0, 1, 16'h0000, 0, 0);
        advance();
      end
    end
    // Finish the outstanding fetch, halt during EXEC
    drive(0, 0, 0, 0, 1, 16'h0002, 0, 0); advance();
    drive(0, 0, 1, 0, 0, 16'h0000, 0, 0); advance();
    drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    check_val("halt_from_exec", halted, 1);

    // Preload the retired counter near its limit, then wrap
    force dut.retired_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    advance();
    release dut.retired_q;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0, 16'h0000, 0, 0); advance();
      drive(0, 0, 0, 0, 1, 16'h0003, 0, 0); advance();
      drive(0, 0, 0, 0, 0, 16'h0000, 0, 0); advance();
      drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
      check_val("retired_near_wrap", retired, (i == 0) ? 16'hFFFF : 16'h0000);
    end
    advance();

    // Reset mid-fetch drops rom_req without a clock
    drive(0, 1, 0, 0, 0, 16'h0000, 0, 0); advance();
    drive(0, 1, 0, 0, 0, 16'h0000, 0, 0);
    check_val("pre_rst_req", rom_req, 1);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check_val("async_rst_req", rom_req, 0);
    check_val("async_rst_pcreset", pc_reset, 1);
    advance();

    // Fetch timeout -> sticky fault
    drive(1, 0, 0, 0, 0, 16'h0000, 0, 0); advance();
    drive(0, 1, 0, 0, 0, 16'h0000, 0, 0); advance();
    drive(0, 1, 0, 0, 0, 16'h0000, 0, 0); advance();
    for (int i = 0; i < MAXW; i++) begin
      drive(0, 1, 0, 0, 0, 16'h0000, 0, 0);
      check_val("fault_not_yet", fault, 0);
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, (i % 2) == 0, 1, 1, 1, 16'hE307, 0, 0);
      check_val("fault_sticky", fault, 1);
      advance();
    end
    drive(1, 0, 0, 0, 0, 16'h0000, 0, 0);
    check_val("fault_cleared", fault, 0);
    advance();

    // Randomized traffic with periodic resets
    for (int i = 0; i < 800; i++) begin
      rrst = ((i % 60) == 0);
      rr   = ($urandom_range(0, 3) != 0);
      rh   = ($urandom_range(0, 7) == 0);
      rs   = ($urandom_range(0, 3) == 0);
      ra   = ($urandom_range(0, 3) != 0);
      rz   = ($urandom_range(0, 1) == 1);
      rn   = ($urandom_range(0, 1) == 1);
      rw   = 16'($urandom);
      drive(rrst, rr, rh, rs, ra, rw, rz, rn);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/student_fetch_ctrl.md
STUDENT_FETCH_CTRL -- requirements
Module: student_fetch_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15, meaning the number of FETCH cycles without rom_ack before FAULT; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  start or resume execution (level-sampled).
REQ-005 halt_req  input  1  request a stop at the next instruction boundary.
REQ-006 step  input  1  execute exactly one instruction while halted.
REQ-007 instr  input  16  instruction word from ROM, valid when rom_ack=1.
REQ-008 rom_ack  input  1  ROM data valid.
REQ-009 zr, ng  input  1 each  ALU zero and negative flags for the current ir.
REQ-010 rom_req  output  1  instruction fetch request.
REQ-011 ir  output  16  latched current instruction.
REQ-012 exec_en  output  1  one-cycle commit strobe for A/D/M writes.
REQ-013 pc_load, pc_inc, pc_reset  output  1 each  PC control.
REQ-014 halted, fault  output  1 each  status.
REQ-015 retired  output  16  count of executed instructions.

Function
REQ-016 The block SHALL have the states RST_PC, IDLE, FETCH, EXEC, HALT and FAULT.
REQ-017 RST_PC SHALL assert pc_reset=1 for exactly one cycle and then go to IDLE.
REQ-018 IDLE SHALL go to FETCH when run=1 and otherwise hold.
REQ-019 FETCH SHALL assert rom_req=1; when rom_ack=1 it SHALL latch instr into ir and go to EXEC (same-cycle ack allowed, so the minimum is 2 cycles per instruction).
REQ-020 FETCH SHALL count cycles spent waiting; when MAX_WAIT consecutive cycles pass without rom_ack, it SHALL go to FAULT; the counter clears on entry to FETCH.
REQ-021 EXEC SHALL last exactly one cycle, with exec_en=1 and exactly one of pc_load or pc_inc asserted.
REQ-022 The jump condition SHALL be: ir[15]=1 and ((ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~zr & ~ng)).
REQ-023 pc_load SHALL equal the jump condition, and pc_inc SHALL equal its inverse.
REQ-024 An A-instruction (ir[15]=0) SHALL always produce pc_inc.
REQ-025 retired SHALL increment by 1 on every EXEC cycle and wrap from 0xFFFF to 0x0000.
REQ-026 EXEC SHALL go to HALT if halt_req=1 or step mode is set, and to FETCH otherwise.
REQ-027 halt_req asserted during FETCH SHALL NOT abort the fetch; the current instruction completes first.
REQ-028 HALT SHALL assert halted=1; run=1 SHALL clear step mode and go to FETCH; step=1 with run=0 SHALL set step mode and go to FETCH.
REQ-029 When run and step are asserted together in HALT, run SHALL win.
REQ-030 halt_req SHALL be ignored while in HALT, IDLE or FAULT.
REQ-031 FAULT SHALL be sticky until reset, with fault=1 and all control outputs 0.
REQ-032 rom_req, exec_en, pc_load, pc_inc and pc_reset SHALL be 0 in every state not listed above.

Reset
REQ-033 reset=1 SHALL immediately (asynchronously) force state RST_PC, ir=0x0000, retired=0x0000, step mode=0 and wait counter=0.
REQ-034 While reset=1, all outputs except pc_reset SHALL be 0, and pc_reset SHALL be 1.
REQ-035 After release, RST_PC SHALL hold for one clock before IDLE.
REQ-036 A reset mid-FETCH or mid-EXEC SHALL drop rom_req and exec_en without waiting for a clock and without incrementing retired.

Structure
REQ-037 The state encoding, the ir bit indices (opcode bit 15, jump bits 2:0) and the MAX_WAIT default SHALL live in the shared package student_cpu_pkg.
REQ-038 The jump decode SHALL be a combinational sub-module named student_jump_unit (inputs ir, zr, ng; output jump).
REQ-039 The state register and the counters SHALL be in student_fetch_ctrl.

Verification
REQ-040 Reset release, run=1, instr=0x0005 with ack on the first FETCH cycle -> pc_reset pulse in cycle 1, then EXEC with pc_inc=1, exec_en=1, and retired=1.
REQ-041 instr=0xE302 (C-instr, JEQ) with zr=1 -> pc_load=1, pc_inc=0; the same instr with zr=0, ng=1 -> pc_inc=1.
REQ-042 instr=0xE307 (JMP) with any flags -> pc_load=1; instr=0x7FFF (A-instr) -> pc_inc=1.
REQ-043 With MAX_WAIT=3 and rom_ack held 0 -> fault=1 after the 3rd FETCH cycle, remaining set under run/step, cleared only by reset.
REQ-044 halt_req pulsed mid-FETCH with ack 2 cycles later -> the instruction completes, then HALT; step pulse -> exactly one EXEC, retired+1, back to HALT; run and step together -> continuous execution.
REQ-045 retired preloaded near the limit by executing 65535 instructions, then one more -> retired wraps to 0x0000; reset asserted mid-FETCH -> rom_req=0 within the same cycle.
